// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and master FSM state encoding.
// Used by the master and the slave-side blocks.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master; AXI valids rise 1 cycle after command accept, rsp held until rsp_ready.
// cmd_ready only in IDLE; AXI4_LITE_MASTER_WSTRB_EN adds a per-command cmd_wstrb, otherwise all bytes are written.
module axi4_lite_master #(
  parameter int AXI_ADDRESS_WIDTH = 32,
  parameter int AXI_DATA_WIDTH    = 32
) (
  input  logic                         m_axi_ctrl_aclk,
  input  logic                         m_axi_ctrl_areset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [AXI_ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]    cmd_wdata,
`ifdef AXI4_LITE_MASTER_WSTRB_EN
  input  logic [3:0]                   cmd_wstrb,
`endif
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_write,
  output logic [AXI_DATA_WIDTH-1:0]    rsp_rdata,
  output logic [1:0]                   rsp_resp,
  output logic                         busy,
  output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_ctrl_awaddr,
  output logic [2:0]                   m_axi_ctrl_awprot,
  output logic                         m_axi_ctrl_awvalid,
  input  logic                         m_axi_ctrl_awready,
  output logic [AXI_DATA_WIDTH-1:0]    m_axi_ctrl_wdata,
  output logic [3:0]                   m_axi_ctrl_wstrb,
  output logic                         m_axi_ctrl_wvalid,
  input  logic                         m_axi_ctrl_wready,
  input  logic [1:0]                   m_axi_ctrl_bresp,
  input  logic                         m_axi_ctrl_bvalid,
  output logic                         m_axi_ctrl_bready,
  output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_ctrl_araddr,
  output logic [2:0]                   m_axi_ctrl_arprot,
  output logic                         m_axi_ctrl_arvalid,
  input  logic                         m_axi_ctrl_arready,
  input  logic [AXI_DATA_WIDTH-1:0]    m_axi_ctrl_rdata,
  input  logic [1:0]                   m_axi_ctrl_rresp,
  input  logic                         m_axi_ctrl_rvalid,
  output logic                         m_axi_ctrl_rready
);
  import axi4_lite_pkg::*;

  state_t                       state;
  logic [AXI_ADDRESS_WIDTH-1:0] addr_reg;
  logic [AXI_DATA_WIDTH-1:0]    wdata_reg;
  logic                         aw_done;
  logic                         w_done;

  assign cmd_ready          = (state == ST_IDLE);
  assign busy               = (state != ST_IDLE);
  assign m_axi_ctrl_awaddr  = addr_reg;
  assign m_axi_ctrl_araddr  = addr_reg;
  assign m_axi_ctrl_wdata   = wdata_reg;
  assign m_axi_ctrl_awprot  = 3'b000;
  assign m_axi_ctrl_arprot  = 3'b000;

  // A channel is finished once its valid has dropped or its handshake happens this cycle.
  assign aw_done = !m_axi_ctrl_awvalid || m_axi_ctrl_awready;
  assign w_done  = !m_axi_ctrl_wvalid  || m_axi_ctrl_wready;

`ifdef AXI4_LITE_MASTER_WSTRB_EN
  logic [3:0] wstrb_reg;
  assign m_axi_ctrl_wstrb = wstrb_reg;
`else
  assign m_axi_ctrl_wstrb = 4'b1111;
`endif

  always_ff @(posedge m_axi_ctrl_aclk) begin
    if (m_axi_ctrl_areset) begin
      state              <= ST_IDLE;
      addr_reg           <= '0;
      wdata_reg          <= '0;
`ifdef AXI4_LITE_MASTER_WSTRB_EN
      wstrb_reg          <= '0;
`endif
      m_axi_ctrl_awvalid <= 1'b0;
      m_axi_ctrl_wvalid  <= 1'b0;
      m_axi_ctrl_arvalid <= 1'b0;
      m_axi_ctrl_bready  <= 1'b0;
      m_axi_ctrl_rready  <= 1'b0;
      rsp_valid          <= 1'b0;
      rsp_write          <= 1'b0;
      rsp_rdata          <= '0;
      rsp_resp           <= RESP_OKAY;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_reg  <= cmd_addr;
            wdata_reg <= cmd_wdata;
            rsp_write <= cmd_write;
`ifdef AXI4_LITE_MASTER_WSTRB_EN
            wstrb_reg <= cmd_wstrb;
`endif
            if (cmd_write) begin
              m_axi_ctrl_awvalid <= 1'b1;
              m_axi_ctrl_wvalid  <= 1'b1;
              state              <= ST_WRITE;
            end else begin
              m_axi_ctrl_arvalid <= 1'b1;
              state              <= ST_RADDR;
            end
          end
        end
        ST_WRITE: begin
          if (m_axi_ctrl_awready) m_axi_ctrl_awvalid <= 1'b0;
          if (m_axi_ctrl_wready)  m_axi_ctrl_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            m_axi_ctrl_bready <= 1'b1;
            state             <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (m_axi_ctrl_bvalid) begin
            m_axi_ctrl_bready <= 1'b0;
            rsp_resp          <= m_axi_ctrl_bresp;
            rsp_rdata         <= '0;
            rsp_valid         <= 1'b1;
            state             <= ST_RESP;
          end
        end
        ST_RADDR: begin
          if (m_axi_ctrl_arready) begin
            m_axi_ctrl_arvalid <= 1'b0;
            m_axi_ctrl_rready  <= 1'b1;
            state              <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (m_axi_ctrl_rvalid) begin
            m_axi_ctrl_rready <= 1'b0;
            rsp_resp          <= m_axi_ctrl_rresp;
            rsp_rdata         <= m_axi_ctrl_rdata;
            rsp_valid         <= 1'b1;
            state             <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi4_lite_master.md
AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

Interface
REQ-001 SHALL have parameter AXI_ADDRESS_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, AXI data width (32 only).
REQ-003 SHALL have one clock and a synchronous active-high reset, ports listed first:
- m_axi_ctrl_aclk  in  1  sole clock, all logic on rising edge.
- m_axi_ctrl_areset  in  1  synchronous active-high reset.
REQ-004 SHALL have these command-side ports:
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AXI_ADDRESS_WIDTH  target byte address.
- cmd_wdata  in  AXI_DATA_WIDTH  write data, ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when valid&ready.
- rsp_write  out  1  response belongs to a write.
- rsp_rdata  out  AXI_DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP as returned.
- busy  out  1  high whenever the state is not IDLE.
REQ-005 SHALL have full AXI4-Lite master ports m_axi_ctrl_{awaddr, awprot[2:0], awvalid, awready, wdata, wstrb[3:0], wvalid, wready, bresp, bvalid, bready, araddr, arprot[2:0], arvalid, arready, rdata, rresp, rvalid, rready}, with standard directions and widths.

Function
REQ-006 SHALL implement FSM states IDLE, WRITE, WRESP, RADDR, RDATA, RESP; one outstanding transaction only.
REQ-007 SHALL assert cmd_ready only in IDLE (combinational from state).
REQ-008 SHALL, on accept in IDLE, latch addr/wdata/write and go to WRITE (write) or RADDR (read); registered valids rise on the next cycle (1-cycle latency).
REQ-009 SHALL, in WRITE, assert awvalid and wvalid together and drop each independently on its own handshake; it SHALL go to WRESP once both handshakes have occurred, including the same-cycle case.
REQ-010 SHALL hold awaddr/wdata/wstrb stable while the corresponding valid is high and never drop a valid before its ready.
REQ-011 SHALL, in WRESP, hold bready high, capture bresp on bvalid, set rsp_rdata = 0 and go to RESP.
REQ-012 SHALL, in RADDR, assert arvalid until arready, then go to RDATA.
REQ-013 SHALL, in RDATA, hold rready high, capture rdata/rresp on rvalid and go to RESP.
REQ-014 SHALL, in RESP, assert rsp_valid with stable payload until rsp_ready; it SHALL then go to IDLE, accepting the next command at the earliest one cycle later.
REQ-015 SHALL drive awprot/arprot = 3'b000; bready/rready SHALL be low outside WRESP/RDATA.
REQ-016 SHALL pass SLVERR/DECERR through unmodified and never retry on them.
REQ-017 SHALL ignore bvalid/rvalid arriving in any state other than WRESP/RDATA.

Reset
REQ-018 SHALL, on any edge sampling m_axi_ctrl_areset high, go to IDLE, clear all valids and readies, and zero addr/data/resp registers, including mid-transaction.
REQ-019 SHALL hold all xVALID outputs low for every cycle following a reset-sampled edge.

Configuration
REQ-020 SHALL, with AXI4_LITE_MASTER_WSTRB_EN defined, add input cmd_wstrb[3:0], latch it on accept, and drive it on m_axi_ctrl_wstrb.
REQ-021 SHALL, without AXI4_LITE_MASTER_WSTRB_EN, omit cmd_wstrb and tie m_axi_ctrl_wstrb = 4'b1111.

Structure
REQ-022 SHALL take RESP_OKAY/EXOKAY/SLVERR/DECERR constants and the FSM state encoding from shared package axi4_lite_pkg, also used by the slave-side blocks.
REQ-023 SHALL be a single flat module with no sub-module.

Verification
REQ-024 Write addr 0x10, data 0xDEADBEEF, awready/wready tied 1, bresp OKAY -> awvalid and wvalid rise 1 cycle after accept; rsp_write=1, rsp_resp=00, rsp_rdata=0.
REQ-025 Write with wready 3 cycles after awready -> awvalid drops after its handshake; wvalid holds 0xDEADBEEF until wready; exactly one WRESP.
REQ-026 Read addr 0x04, slave returns 0x12345678 with rvalid 5 cycles late -> arvalid 1 cycle, rready high while waiting, rsp_rdata=0x12345678.
REQ-027 Read returning rresp=10 with rsp_ready held low 4 cycles -> rsp_valid and payload stable all 4 cycles, resp=10, cmd_ready low until drained.
REQ-028 Reset asserted while awvalid is high and awready is low -> next cycle all valids 0, busy 0, cmd_ready 1.
REQ-029 WSTRB_EN build, cmd_wstrb=4'b0011 -> m_axi_ctrl_wstrb=0011; non-EN build -> 1111.
